// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32 subset: fetch/decode/execute/memory/writeback sequencing
// with bounded memory waits, halt on SYSTEM or illegal opcodes, and a retired-instruction count.
module multicycle_control #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [1:0]  alu_op,
    output logic [1:0]  imm_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic        timeout,
    output logic [31:0] retired_count
);

    localparam int unsigned CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_SYSTEM  = 3'd5,
        CLS_ILLEGAL = 3'd6
    } cls_t;

    state_t        state_q, state_d;
    cls_t          cls_q, cls_dec;
    logic [CW-1:0] wait_cnt;
    logic          wait_expired;
    logic          illegal_set;
    logic          timeout_set;

    assign state        = state_q;
    assign halted       = (state_q == HALT);
    assign wait_expired = (wait_cnt == CW'(MEM_WAIT_MAX));

    always_comb begin
        case (opcode)
            7'b0110011: cls_dec = CLS_R;
            7'b0010011: cls_dec = CLS_I;
            7'b0000011: cls_dec = CLS_LOAD;
            7'b0100011: cls_dec = CLS_STORE;
            7'b1100011: cls_dec = CLS_BRANCH;
            7'b1110011: cls_dec = CLS_SYSTEM;
            default:    cls_dec = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_op      = 2'b00;
        alu_src     = 1'b0;
        imm_sel     = 2'b00;
        illegal_set = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            IDLE: if (run) state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = DECODE;
                end else if (wait_expired) begin
                    timeout_set = 1'b1;
                    state_d     = HALT;
                end
            end
            DECODE: begin
                case (cls_dec)
                    CLS_SYSTEM:  state_d = HALT;
                    CLS_ILLEGAL: begin
                        illegal_set = 1'b1;
                        state_d     = HALT;
                    end
                    default:     state_d = EXECUTE;
                endcase
            end
            EXECUTE: begin
                case (cls_q)
                    CLS_R, CLS_I:         state_d = WRITEBACK;
                    CLS_LOAD, CLS_STORE:  state_d = MEMORY;
                    CLS_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
                        state_d  = FETCH;
                    end
                    default: begin
                        illegal_set = 1'b1;
                        state_d     = HALT;
                    end
                endcase
            end
            MEMORY: begin
                mem_read  = (cls_q == CLS_LOAD);
                mem_write = (cls_q == CLS_STORE);
                // A ready seen while the counter sits at the limit still completes the access.
                if (dmem_ready) begin
                    if (cls_q == CLS_LOAD) begin
                        state_d = WRITEBACK;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end
                end else if (wait_expired) begin
                    timeout_set = 1'b1;
                    state_d     = HALT;
                end
            end
            WRITEBACK: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == CLS_LOAD);
                pc_write   = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = HALT;
        endcase

        if (state_q == EXECUTE || state_q == MEMORY || state_q == WRITEBACK) begin
            case (cls_q)
                CLS_R:      begin alu_op = 2'b10; alu_src = 1'b0; imm_sel = 2'b11; end
                CLS_I:      begin alu_op = 2'b11; alu_src = 1'b1; imm_sel = 2'b00; end
                CLS_LOAD:   begin alu_op = 2'b00; alu_src = 1'b1; imm_sel = 2'b00; end
                CLS_STORE:  begin alu_op = 2'b00; alu_src = 1'b1; imm_sel = 2'b01; end
                CLS_BRANCH: begin alu_op = 2'b01; alu_src = 1'b0; imm_sel = 2'b10; end
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cls_q         <= CLS_R;
            wait_cnt      <= '0;
            illegal       <= 1'b0;
            timeout       <= 1'b0;
            retired_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) cls_q <= cls_dec;
            if (illegal_set) illegal <= 1'b1;
            if (timeout_set) timeout <= 1'b1;
            if (pc_write) retired_count <= retired_count + 32'd1;
            // Every state change clears the counter, which covers entry to FETCH and MEMORY.
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if ((state_q == FETCH && !imem_ready) || (state_q == MEMORY && !dmem_ready)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15, is the maximum number of cycles a memory request may wait for its ready signal before timeout.
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 run  input  1  start request, sampled only in IDLE.
REQ-005 opcode  input  7  instruction[6:0] from the instruction register.
REQ-006 funct3  input  3  instruction[14:12] from the instruction register.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 imem_ready  input  1  instruction-memory data valid.
REQ-009 dmem_ready  input  1  data-memory access complete.
REQ-010 imem_req, ir_write, pc_write, pc_src, reg_write, mem_read, mem_write, alu_src, mem_to_reg  output  1 each  datapath controls.
REQ-011 alu_op  output  2  00 add, 01 sub, 10 R-type funct, 11 I-type funct.
REQ-012 imm_sel  output  2  00 I, 01 S, 10 B, 11 none.
REQ-013 state  output  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
REQ-014 halted, illegal, timeout  output  1 each  status flags.
REQ-015 retired_count  output  32  count of completed instructions.

Function
REQ-016 The instruction class is registered in DECODE as R (0110011), I (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011) or SYSTEM (1110011); any other opcode is illegal.
REQ-017 IDLE: all controls 0; run=1 moves to FETCH on the next edge.
REQ-018 FETCH: imem_req=1 held until imem_ready=1; ir_write=1 in exactly the cycle imem_ready=1; next state is DECODE.
REQ-019 DECODE: a legal non-SYSTEM class moves to EXECUTE; SYSTEM moves to HALT with illegal=0; an illegal opcode moves to HALT with illegal=1.
REQ-020 alu_op, alu_src and imm_sel are driven from the registered class in EXECUTE, MEMORY and WRITEBACK, and are 0 in all other states.
REQ-021 Class encodings: R gives alu_op=10, alu_src=0, imm_sel=11; I gives 11/1/00; LOAD gives 00/1/00; STORE gives 00/1/01; BRANCH gives 01/0/10.
REQ-022 EXECUTE: R and I move to WRITEBACK; LOAD and STORE move to MEMORY; BRANCH moves to FETCH with pc_write=1.
REQ-023 BRANCH pc_src is 1 when (funct3=000 and zero=1) or (funct3=001 and zero=0), else 0; pc_src is 0 in all other cycles.
REQ-024 MEMORY: LOAD asserts mem_read and STORE asserts mem_write, held until dmem_ready=1.
REQ-025 On dmem_ready=1, LOAD moves to WRITEBACK, and STORE moves to FETCH with pc_write=1 in that cycle.
REQ-026 WRITEBACK: reg_write=1, mem_to_reg=1 only for LOAD, pc_write=1, and the next state is FETCH.
REQ-027 pc_write is asserted exactly once per instruction, in its final cycle; retired_count increments by 1 on that same edge and wraps from FFFFFFFF to 0.
REQ-028 A wait counter clears on entry to FETCH and MEMORY and counts each cycle the ready signal is low.
REQ-029 If the wait counter reaches MEM_WAIT_MAX while ready is still low, the block moves to HALT with timeout=1 and all request signals drop.
REQ-030 A ready signal arriving in the cycle the counter reaches MEM_WAIT_MAX takes priority, so no timeout occurs.
REQ-031 HALT: halted=1, all controls 0, the state holds until reset; run is ignored.
REQ-032 imem_ready or dmem_ready asserted outside its request state is ignored.

Reset
REQ-033 reset_n=0 at a rising edge forces state=IDLE, clears all outputs, clears retired_count, clears the status flags, clears the wait counter and clears the registered class.
REQ-034 Reset takes effect in any state, including mid-MEMORY, and overrides every simultaneous event.

Verification
REQ-035 ADD with imem_ready after 2 cycles: FETCH is 3 cycles, then DECODE, EXECUTE and WRITEBACK; reg_write=1 and pc_write=1 in WRITEBACK; retired_count=1.
REQ-036 LOAD with dmem_ready after 3 cycles: mem_read=1 for 4 cycles, then WRITEBACK with mem_to_reg=1; STORE gives pc_write=1 in the MEMORY exit cycle and reg_write never asserts.
REQ-037 BEQ with zero=1 gives pc_src=1 and pc_write=1 in EXECUTE; BNE with zero=1 gives pc_src=0.
REQ-038 Opcode 1111111 gives HALT with illegal=1; opcode 1110011 gives HALT with illegal=0; subsequent run pulses are ignored.
REQ-039 dmem_ready held low gives timeout=1 and halted=1 after exactly 15 wait cycles; dmem_ready arriving on cycle 15 gives no timeout.
REQ-040 reset_n=0 during MEMORY gives state=0, mem_read=0 and retired_count=0 on the next edge.
